// File: rtl/mem_pkg.sv
// Shared types and default geometry for the unified instruction/data memory responder.
package mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH  = 16;
    localparam int unsigned MEM_DATA_WIDTH  = 32;
    localparam int unsigned MEM_DEPTH_LOG2  = 8;
    localparam int unsigned MEM_WAIT_CYCLES = 2;
    localparam logic [15:0] MEM_TEXT_LIMIT  = 16'h0100;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; read data is registered and held until the next read.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Unified memory responder serving instruction fetches and data accesses with fixed wait states.
// Optional write protection of the text region is enabled by defining MEM_TEXT_PROTECT_EN.
module unified_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int unsigned           DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int unsigned           DEPTH_LOG2  = MEM_DEPTH_LOG2,
    parameter int unsigned           WAIT_CYCLES = MEM_WAIT_CYCLES,
    parameter logic [ADDR_WIDTH-1:0] TEXT_LIMIT  = ADDR_WIDTH'(MEM_TEXT_LIMIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_ifetch,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_ifetch,
    output logic                  resp_err
);

    localparam bit NoWait = (WAIT_CYCLES == 0);
`ifdef MEM_TEXT_PROTECT_EN
    localparam bit TextProtect = 1'b1;
`else
    localparam bit TextProtect = 1'b0;
`endif

    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q, ifetch_q;

    logic                  accept, access;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_we, acc_ifetch, acc_err;

    logic                  resp_err_q, resp_ifetch_q, rd_ok_q;
    logic                  ram_en;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        accept     = req_valid & req_ready;
        access     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (NoWait) begin
                        state_d = StResp;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    cnt_d   = '0;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Zero wait states access the array on the acceptance edge, straight from the request port.
    assign acc_addr   = NoWait ? req_addr   : addr_q;
    assign acc_wdata  = NoWait ? req_wdata  : wdata_q;
    assign acc_we     = NoWait ? req_we     : we_q;
    assign acc_ifetch = NoWait ? req_ifetch : ifetch_q;

    assign acc_err = (acc_addr[1:0] != 2'b00)
                   | (acc_we & acc_ifetch)
                   | (TextProtect & acc_we & ~acc_ifetch & (acc_addr < TEXT_LIMIT));

    // Reset on the access edge must suppress the write.
    assign ram_en = access & ~acc_err & ~rst;

    mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_we),
        .addr (acc_addr[DEPTH_LOG2+1:2]),
        .wdata(acc_wdata),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            ifetch_q      <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_ifetch_q <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                we_q     <= req_we;
                ifetch_q <= req_ifetch;
            end
            if (access) begin
                resp_err_q    <= acc_err;
                resp_ifetch_q <= acc_ifetch;
                rd_ok_q       <= ~acc_we & ~acc_err;
            end else if ((state_q == StResp) && resp_ready) begin
                resp_err_q    <= 1'b0;
                resp_ifetch_q <= 1'b0;
                rd_ok_q       <= 1'b0;
            end
        end
    end

    assign resp_rdata  = rd_ok_q ? ram_rdata : '0;
    assign resp_err    = resp_err_q;
    assign resp_ifetch = resp_ifetch_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Randomized scoreboard bench for unified_mem_responder against a word-array reference model.
module tb_unified_mem_responder;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned DL = 8;
    localparam int unsigned W  = 2;
    localparam int unsigned NW = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_ifetch = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_rdata;
    logic          resp_ifetch;
    logic          resp_err;

    unified_mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .WAIT_CYCLES(W),
        .TEXT_LIMIT (16'h0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_ifetch (req_ifetch),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_ifetch(resp_ifetch),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        bit            err;
        bit            ifetch;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [NW];
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    int            ready_mode = 0;  // 0 random, 1 held low, 2 held high
    bit            front_seen = 1'b0;
    bit            prev_cons = 1'b0;

`ifdef MEM_TEXT_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Consumer-side ready, changed just after the edge so negedge samples are stable.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       resp_ready = 1'b0;
            2:       resp_ready = 1'b1;
            default: resp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_cons  = 1'b0;
            front_seen = 1'b0;
        end else begin
            if (prev_cons) begin
                chk("idle_after_consume_valid", {31'b0, resp_valid}, 32'd0);
                chk("idle_after_consume_ready", {31'b0, req_ready}, 32'd1);
            end
            prev_cons = 1'b0;
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    if (!front_seen) begin
                        chk("latency", 32'(cyc - exp_q[0].acc), 32'(1 + W));
                        front_seen = 1'b1;
                    end
                    chk("rdata", resp_rdata, exp_q[0].rdata);
                    chk("err", {31'b0, resp_err}, {31'b0, exp_q[0].err});
                    chk("ifetch", {31'b0, resp_ifetch}, {31'b0, exp_q[0].ifetch});
                    chk("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        front_seen = 1'b0;
                        prev_cons  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic issue(input bit ifetch, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        int   n = 0;
        exp_t e;
        int   idx;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        idx      = int'(addr[DL+1:2]);
        e.err    = (addr[1:0] != 2'b00) || (we && ifetch) ||
                   (PROT && we && !ifetch && (addr < 16'h0100));
        e.rdata  = (!we && !e.err) ? model[idx] : '0;
        e.ifetch = ifetch;
        e.acc    = cyc;
        if (we && !e.err) model[idx] = wdata;
        exp_q.push_back(e);
        req_valid  = 1'b1;
        req_ifetch = ifetch;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        chk("rst_ifetch", {31'b0, resp_ifetch}, 32'd0);
        rst = 1'b0;

        // Preload every word through an alias above the text region.
        for (int i = 0; i < int'(NW); i++) begin
            issue(1'b0, 1'b1, 16'h0400 + 16'(i * 4), $urandom);
        end

        issue(1'b0, 1'b1, 16'h0200, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 16'h0200, '0);
        issue(1'b0, 1'b0, 16'h0203, '0);
        issue(1'b0, 1'b0, 16'h0200, '0);
        issue(1'b1, 1'b1, 16'h0300, 32'h12345678);
        issue(1'b1, 1'b0, 16'h0300, '0);
        drain();

        // Back-pressure: hold the response for several cycles.
        @(negedge clk);
        ready_mode = 1;
        issue(1'b0, 1'b0, 16'h0200, '0);
        repeat (W + 6) @(negedge clk);
        chk("held_valid", {31'b0, resp_valid}, 32'd1);
        ready_mode = 2;
        drain();
        ready_mode = 0;

        // Reset in the wait phase of a write aborts it.
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_ifetch = 1'b0;
        req_we    = 1'b1;
        req_addr  = 16'h0400;
        req_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (W + 2) @(negedge clk);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        issue(1'b0, 1'b0, 16'h0400, '0);

        issue(1'b0, 1'b1, 16'h0010, 32'hCAFEF00D);
        issue(1'b0, 1'b0, 16'h0010, '0);

        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom_range(0, 16'h07FF));
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d = $urandom;
            issue($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, d);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unified_mem_responder.md
UNIFIED_MEM_RESPONDER -- requirements
Module: unified_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, is the byte address width of the request port.
REQ-002 Parameter DATA_WIDTH, default 32, is the data word width.
REQ-003 Parameter DEPTH_LOG2, default 8, is log2 of the number of words in the array.
REQ-004 Parameter WAIT_CYCLES, default 2, range 0..15, is the number of access wait states.
REQ-005 Parameter TEXT_LIMIT, default 16'h0100, is the byte address bound of the text region (addresses below it are text).
REQ-006 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-007 Port clk, input, 1, is the system clock.
REQ-008 Port rst, input, 1, is the synchronous active-high reset.
REQ-009 Port req_valid, input, 1, is the request strobe.
REQ-010 Port req_ready, output, 1, means the block can accept a request.
REQ-011 Port req_ifetch, input, 1, marks the request as an instruction fetch (the IorD=1 path) rather than a data access.
REQ-012 Port req_we, input, 1, selects a write when 1 and a read when 0.
REQ-013 Port req_addr, input, ADDR_WIDTH, is the byte address (PC or ALU result).
REQ-014 Port req_wdata, input, DATA_WIDTH, is the write data.
REQ-015 Port resp_valid, output, 1, means a response is present.
REQ-016 Port resp_ready, input, 1, is consumer acceptance of the response.
REQ-017 Port resp_rdata, output, DATA_WIDTH, is the read data (zero for writes and errors).
REQ-018 Port resp_ifetch, output, 1, echoes req_ifetch of the request being answered.
REQ-019 Port resp_err, output, 1, flags a rejected access.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 A request is accepted when req_valid and req_ready are both 1; addr, we, wdata and ifetch SHALL be captured on that edge.
REQ-023 On acceptance the FSM goes IDLE->WAIT with wait counter = WAIT_CYCLES, or IDLE->RESP directly when WAIT_CYCLES=0.
REQ-024 In WAIT the counter decrements each cycle; when it reaches 1 the array access is performed and the FSM goes to RESP.
REQ-025 A response accepted at edge t SHALL assert resp_valid from cycle t+1+WAIT_CYCLES.
REQ-026 In RESP, resp_valid=1 and resp_rdata, resp_err and resp_ifetch SHALL be held stable until resp_ready=1; the FSM then returns to IDLE.
REQ-027 A new request cannot be accepted in the same cycle a response is consumed; the next acceptance is at the earliest one cycle later.
REQ-028 The word index is req_addr[DEPTH_LOG2+1:2]; higher address bits are ignored, so addresses wrap modulo the array size.
REQ-029 Misaligned access (addr[1:0]!=0) SHALL produce resp_err=1 and resp_rdata=0, with no array write.
REQ-030 Write with req_ifetch=1 SHALL produce resp_err=1 and no array write.
REQ-031 A valid write SHALL update the array in its access cycle, and its response SHALL have rdata=0 and err=0.
REQ-032 A read SHALL return the word as it stands at access time, including any write that completed earlier.

Reset
REQ-033 rst SHALL force IDLE, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_ifetch=0.
REQ-034 rst mid-operation SHALL abort any pending request with no array write and no response; array contents are not cleared.

Configuration
REQ-035 With MEM_TEXT_PROTECT_EN defined, any data write (req_ifetch=0) to an address below TEXT_LIMIT SHALL produce resp_err=1 and no write.
REQ-036 Without MEM_TEXT_PROTECT_EN, such writes SHALL proceed normally, and TEXT_LIMIT is unused.

Structure
REQ-037 Package mem_pkg SHALL hold the FSM state type (IDLE/WAIT/RESP), the default widths and the default TEXT_LIMIT.
REQ-038 Storage SHALL be a sub-module mem_array: single-port synchronous RAM of 2^DEPTH_LOG2 x DATA_WIDTH words with a write enable.

Verification
REQ-039 Scenario: write 0xDEADBEEF to 0x0200, then read 0x0200 with WAIT_CYCLES=2 -> read resp_valid exactly 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-040 Scenario: read 0x0203 -> resp_err=1, rdata=0; a following read of 0x0200 is unchanged.
REQ-041 Scenario: ifetch write to 0x0300 -> err=1; ifetch read of 0x0300 returns the prior contents with resp_ifetch=1.
REQ-042 Scenario: hold resp_ready=0 for 5 cycles -> resp_valid and rdata stay stable and req_ready stays 0; release -> back in IDLE next cycle.
REQ-043 Scenario: assert rst during WAIT of a write to 0x0400 -> no response, req_ready=1 after reset, and 0x0400 is unchanged.
REQ-044 Scenario: with MEM_TEXT_PROTECT_EN, data write to 0x0010 -> err=1 and no write; without the macro -> err=0 and the write lands.
